// File: rtl/my_add_pkg.sv
// Purpose : shared constants for the my_add adder slice.
// Latency : n/a (constants only).
// Backpressure: n/a.
package my_add_pkg;

    // Width of one carry-lookahead group; carries ripple between groups.
    localparam int ADD_GROUP_W = 4;

endpackage : my_add_pkg

// File: rtl/my_add_cla4_group.sv
// Purpose : 4-bit carry-lookahead group: sum, carry-out and group P/G.
// Latency : purely combinational.
// Backpressure: none; no handshake.
//
// Ports:
//   a, b   in   4-bit operand slices
//   cin    in   carry into bit 0 of the group
//   sum    out  4-bit sum slice
//   cout   out  carry out of bit 3 (feeds the next group)
//   grp_p  out  group propagate (all four bits propagate)
//   grp_g  out  group generate (group produces a carry on its own)
module cla4_group
    import my_add_pkg::*;
(
    input  logic [ADD_GROUP_W-1:0] a,
    input  logic [ADD_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [ADD_GROUP_W-1:0] sum,
    output logic                   cout,
    output logic                   grp_p,
    output logic                   grp_g
);

    logic [ADD_GROUP_W-1:0] p;
    logic [ADD_GROUP_W-1:0] g;
    logic [ADD_GROUP_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is expanded down to cin so no carry waits on its neighbour.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = grp_g | (grp_p & cin);

    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

    assign sum  = p ^ c[ADD_GROUP_W-1:0];
    assign cout = c[4];

endmodule : cla4_group

// File: rtl/my_add.sv
// Purpose : registered WIDTH-bit adder, {co,s} = a + b + ci.
// Latency : 1 cycle; operands sampled at edge N show on s/co after edge N.
// Backpressure: none; accepts a new operation every cycle, no stall.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears s and co)
//   a, b   in   WIDTH-bit unsigned operands
//   ci     in   carry-in, weight 1
//   s      out  registered low WIDTH bits of a+b+ci
//   co     out  registered bit WIDTH of a+b+ci
module my_add
    import my_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int NGRP = WIDTH / ADD_GROUP_W;

    if ((WIDTH % ADD_GROUP_W) != 0 || WIDTH < ADD_GROUP_W) begin : g_bad_width
        $error("my_add: WIDTH=%0d must be a multiple of %0d and at least %0d",
               WIDTH, ADD_GROUP_W, ADD_GROUP_W);
    end

    logic [NGRP:0]      carry;
    logic [WIDTH-1:0]   sum_c;
    // Group P/G are kept for a later two-level lookahead; nothing reads them yet.
    logic [NGRP-1:0]    unused_grp_p;
    logic [NGRP-1:0]    unused_grp_g;

    assign carry[0] = ci;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla4_group u_grp (
            .a     (a[k*ADD_GROUP_W +: ADD_GROUP_W]),
            .b     (b[k*ADD_GROUP_W +: ADD_GROUP_W]),
            .cin   (carry[k]),
            .sum   (sum_c[k*ADD_GROUP_W +: ADD_GROUP_W]),
            .cout  (carry[k+1]),
            .grp_p (unused_grp_p[k]),
            .grp_g (unused_grp_g[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
        end else begin
            s  <= sum_c;
            co <= carry[NGRP];
        end
    end

endmodule : my_add

// File: tb/tb_my_add.sv
// Purpose : directed and random checks of my_add at WIDTH=4.
// Latency : expects results exactly one edge after operands are applied.
// Backpressure: n/a.
module tb_my_add;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;

    int n_cmp = 0;
    int n_err = 0;

    my_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got {co,s}=%b, expected %b", tag, obs, exp_v);
        end
    endtask

    // Directed vectors: a, b, ci and hand-computed {co,s}.
    logic [W-1:0] va  [9] = '{4'b0001, 4'b0010, 4'b0010, 4'b0011, 4'b0111,
                              4'b0011, 4'b0001, 4'b0111, 4'b1111};
    logic [W-1:0] vb  [9] = '{4'b1010, 4'b1010, 4'b1110, 4'b1100, 4'b1001,
                              4'b1100, 4'b1100, 4'b1111, 4'b1111};
    logic         vci [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1};
    logic [W:0]   vexp[9] = '{5'b0_1011, 5'b0_1101, 5'b1_0000, 5'b1_0000, 5'b1_0000,
                              5'b0_1111, 5'b0_1110, 5'b1_0111, 5'b1_1111};

    initial begin
        logic [W:0] prev;
        logic [W:0] exp_r;

        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;

        #1;
        chk("reset_init", {co, s}, 5'b0_0000);
        @(posedge clk); #1;
        chk("reset_edge", {co, s}, 5'b0_0000);
        rst_n = 1'b1;

        // Back-to-back directed vectors, new operands every cycle.
        a = va[0]; b = vb[0]; ci = vci[0];
        #2;
        chk("no_early_update", {co, s}, 5'b0_0000);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {co, s}, vexp[i]);
            prev = {co, s};
            if (i < 8) begin
                a = va[i+1]; b = vb[i+1]; ci = vci[i+1];
            end else begin
                a = 4'b0000; b = 4'b0000; ci = 1'b0;
            end
            #2;
            chk($sformatf("hold%0d", i), {co, s}, vexp[i]);
        end

        // Reset mid-run discards the result and clears outputs without an edge.
        a = 4'd7; b = 4'd15; ci = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset", {co, s}, 5'b1_0111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async", {co, s}, 5'b0_0000);
        @(posedge clk); #1;
        chk("reset_hold1", {co, s}, 5'b0_0000);
        @(posedge clk); #1;
        chk("reset_hold2", {co, s}, 5'b0_0000);
        #2;
        rst_n = 1'b1;
        #1;
        chk("release_no_edge", {co, s}, 5'b0_0000);
        @(posedge clk); #1;
        chk("release_first", {co, s}, 5'b1_0111);

        // Random back-to-back run against a plain arithmetic model.
        for (int i = 0; i < 500; i++) begin
            a  = W'($urandom_range(0, 15));
            b  = W'($urandom_range(0, 15));
            ci = 1'($urandom_range(0, 1));
            exp_r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            @(posedge clk); #1;
            chk($sformatf("rnd%0d", i), {co, s}, exp_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_my_add
